// File: rtl/xbus_ic.sv
// xbus_ic: base/mask decoding interconnect from the xctrl data bus to N wait-state slaves with error tracking
module xbus_ic #(
  parameter int N_SLV = 8,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '0,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m_sel,
  input  logic                    m_we,
  input  logic [ADDR_W-1:0]       m_addr,
  input  logic [DATA_W-1:0]       m_wdata,
  output logic [DATA_W-1:0]       m_rdata,
  output logic                    m_ready,
  output logic                    m_err,
  output logic [N_SLV-1:0]        s_sel,
  output logic                    s_we,
  output logic [ADDR_W-1:0]       s_addr,
  output logic [DATA_W-1:0]       s_wdata,
  input  logic [N_SLV*DATA_W-1:0] s_rdata,
  input  logic [N_SLV-1:0]        s_ready,
  output logic [7:0]              err_cnt,
  output logic [ADDR_W-1:0]       err_addr
);
  localparam int IW = N_SLV > 1 ? $clog2(N_SLV) : 1;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [N_SLV-1:0] s_sel_q, s_sel_d;
  logic s_we_q, s_we_d, m_ready_q, m_ready_d, m_err_q, m_err_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d, err_addr_q, err_addr_d;
  logic [DATA_W-1:0] s_wdata_q, s_wdata_d, m_rdata_q, m_rdata_d;
  logic [IW-1:0] idx_q, idx_d, hit_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic hit, err_evt;
  // descending scan so the lowest matching index is the one left standing
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--)
      if ((m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
  end
  always_comb begin
    state_d = state_q;
    s_sel_d = s_sel_q;
    s_we_d = s_we_q;
    s_addr_d = s_addr_q;
    s_wdata_d = s_wdata_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    m_rdata_d = m_rdata_q;
    err_evt = 1'b0;
    case (state_q)
      IDLE: if (m_sel) begin
        s_we_d = m_we;
        s_addr_d = m_addr;
        s_wdata_d = m_wdata;
        idx_d = hit_idx;
        cnt_d = '0;
        s_sel_d = hit ? N_SLV'(1) << hit_idx : '0;
        state_d = hit ? ACCESS : RESP;
        err_evt = !hit;
      end
      ACCESS: if (s_ready[idx_q]) begin
        s_sel_d = '0;
        state_d = RESP;
        m_rdata_d = s_we_q ? '0 : s_rdata[idx_q*DATA_W +: DATA_W];
      end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
        s_sel_d = '0;
        state_d = RESP;
        err_evt = 1'b1;
      end else
        cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
    m_rdata_d = err_evt ? '0 : m_rdata_d;
    m_ready_d = state_d == RESP;
    m_err_d = state_d == RESP ? err_evt : m_err_q;
    err_cnt_d = err_evt ? err_cnt_q + {7'd0, err_cnt_q != 8'hFF} : err_cnt_q;
    err_addr_d = err_evt ? s_addr_d : err_addr_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      s_sel_q <= '0;
      s_we_q <= 1'b0;
      s_addr_q <= '0;
      s_wdata_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      m_rdata_q <= '0;
      m_ready_q <= 1'b0;
      m_err_q <= 1'b0;
      err_cnt_q <= '0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      s_sel_q <= s_sel_d;
      s_we_q <= s_we_d;
      s_addr_q <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      m_rdata_q <= m_rdata_d;
      m_ready_q <= m_ready_d;
      m_err_q <= m_err_d;
      err_cnt_q <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  assign s_sel = s_sel_q;
  assign s_we = s_we_q;
  assign s_addr = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign m_rdata = m_rdata_q;
  assign m_ready = m_ready_q;
  assign m_err = m_err_q;
  assign err_cnt = err_cnt_q;
  assign err_addr = err_addr_q;
endmodule
